piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in serial-out serializer that feeds the serial input of the team's SIPO shift register. It accepts a DATA_W-bit word through a valid/ready load handshake and emits it MSB first, one bit per enabled cycle. After DATA_W shifts the SIPO holds the original word in its original bit order. Back-to-back words stream with no idle cycle between them.

## Interface
- DATA_W, default 4: word width; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- parallel_in  input  DATA_W  word to serialize; sampled only on an accepted load.
- load_valid  input  1  a word is offered on parallel_in.
- load_ready  output  1  the serializer can accept a word this cycle.
- shift_en  input  1  downstream consumes serial_out at this edge (pacing/stall).
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a frame bit.
- frame_start  output  1  high while the first bit (MSB) of a frame is presented.
- frame_last  output  1  high while the final bit of a frame is presented.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits being presented.
  - PARITY: parity bit being presented; exists only with PISO_PARITY_EN.
- Internal registers:
  - DATA_W-bit shift register, shifting left; serial_out is taken from its MSB.
  - Bit counter, $clog2(DATA_W+1) bits wide.
- Load acceptance: a load is accepted at a clock edge when load_valid && load_ready.
  - The word is captured and the counter is set to DATA_W-1.
  - The state goes to SHIFT.
- SHIFT behaviour:
  - The presented bit is held until an edge with shift_en=1.
  - At that edge the register shifts left and the counter decrements.
  - shift_en=0 freezes all state.
- Frame flags:
  - frame_start is high while count==DATA_W-1 in SHIFT.
  - frame_last is high while the final bit is presented: count==0 in SHIFT (no parity) or in PARITY.
- load_ready:
  - Equals (state==IDLE) || (frame_last && shift_en), forced to 0 while rst=1.
  - It depends combinationally on shift_en; the upstream logic must not loop load_valid back to load_ready.
- Frame end:
  - Final bit consumed with a load accepted at the same edge: go to SHIFT with the new word, no gap cycle.
  - Final bit consumed without a load: go to IDLE.
- Idle outputs: in IDLE, serial_out=0, serial_valid=0, frame_start=0, frame_last=0.
- Input handling:
  - parallel_in is ignored except on an accepted load.
  - load_valid is ignored while a frame is in progress, except in the final-bit case above.
- Reset:
  - Any cycle with rst=1 returns to IDLE at that edge and aborts any partial frame.
  - The shift register and counter clear to 0; no bit is emitted for the aborted word.
- Outputs after reset: serial_out=0, serial_valid=0, frame_start=0, frame_last=0, load_ready=1.

## Timing
- Load accepted at edge N: the MSB appears on serial_out, with serial_valid=1, in the cycle after edge N.
- With shift_en held at 1:
  - Bit k (MSB is k=DATA_W-1) is presented in cycle N+DATA_W-k.
  - The frame occupies DATA_W cycles, or DATA_W+1 with parity.
- Sustained throughput with continuous load_valid and shift_en: one word per DATA_W cycles (DATA_W+1 with parity), and serial_valid never drops.
- A stall of S cycles (shift_en=0) extends the frame by exactly S cycles.

## Configuration
- PISO_PARITY_EN defined:
  - After bit 0, one extra PARITY cycle presents the even-parity bit (XOR of the captured word).
  - frame_last marks the parity cycle, not bit 0.
- PISO_PARITY_EN undefined:
  - The PARITY state and its logic are absent.
  - The frame is exactly DATA_W bits, and frame_last marks bit 0.

## Test plan
- Reset then single load: DATA_W=4, load 4'b1011 with shift_en=1.
  - serial_out is 1,0,1,1 over 4 cycles.
  - frame_start in cycle 1 only, frame_last in cycle 4 only.
  - Downstream SIPO parallel_out = 4'b1011 afterwards.
- Back-to-back: 4'hA then 4'h5 with load_valid held.
  - 8 consecutive valid bits 1,0,1,0,0,1,0,1.
  - load_ready pulses only in the final-bit cycles; serial_valid never low.
- Stall: load 4'hC with shift_en=0 for 3 cycles during bit 2.
  - The bit holds for 4 cycles; the frame takes 7 cycles; output order unchanged.
- Reset mid-frame: assert rst after 2 bits of 4'hF.
  - Next cycle: serial_valid=0, load_ready=1.
  - A following load of 4'h3 emits 0,0,1,1 cleanly.
- Load ignored when busy: pulse load_valid with 4'h9 during frame 2 of a 4'h6 transfer.
  - Only 0,1,1,0 is emitted; 4'h9 is not captured.
- PISO_PARITY_EN defined: load 4'b0111.
  - Emits 0,1,1,1 then parity 1; frame_last on the 5th bit.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: valid/ready word load, MSB-first serial stream with stall support.
// Optional even-parity trailer bit is built when PISO_PARITY_EN is defined.
module piso_serializer #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] parallel_in,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic              shift_en,
   output logic              serial_out,
   output logic              serial_valid,
   output logic              frame_start,
   output logic              frame_last
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
   logic parity_bit;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] shift_reg;
   logic [CNT_W-1:0]  count;
   logic              load_accept;

   assign load_accept = load_valid && load_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // A reload on the final-bit edge goes straight back to SHIFT, so frames stream without a gap.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (load_accept) next_state = SHIFT;
         end
         SHIFT: begin
            if (shift_en && count == '0) begin
`ifdef PISO_PARITY_EN
               next_state = PARITY;
`else
               next_state = load_accept ? SHIFT : IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            if (shift_en) next_state = load_accept ? SHIFT : IDLE;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      serial_out   = 1'b0;
      serial_valid = 1'b0;
      frame_start  = 1'b0;
      frame_last   = 1'b0;
      case (state)
         SHIFT: begin
            serial_out   = shift_reg[DATA_W-1];
            serial_valid = 1'b1;
            frame_start  = (count == CNT_TOP);
`ifndef PISO_PARITY_EN
            frame_last   = (count == '0);
`endif
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            serial_out   = parity_bit;
            serial_valid = 1'b1;
            frame_last   = 1'b1;
         end
`endif
         default: ;
      endcase
      // Combinational path from shift_en: upstream must not feed load_ready back into load_valid.
      load_ready = !rst && ((state == IDLE) || (frame_last && shift_en));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         count     <= '0;
`ifdef PISO_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else if (load_accept) begin
         shift_reg <= parallel_in;
         count     <= CNT_TOP;
`ifdef PISO_PARITY_EN
         parity_bit <= ^parallel_in;
`endif
      end else if (state == SHIFT && shift_en) begin
         shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
         if (count != '0) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus random traffic against a frame-queue reference model.
module tb_piso_serializer;

   localparam int DATA_W = 4;
`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] parallel_in;
   logic              load_valid;
   logic              load_ready;
   logic              shift_en;
   logic              serial_out;
   logic              serial_valid;
   logic              frame_start;
   logic              frame_last;

   int                checks = 0;
   int                failures = 0;
   string             cur_step = "init";
   bit                model_frame[$];
   int                model_pos = 0;
   logic [DATA_W-1:0] sipo = '0;
   logic [DATA_W-1:0] word;
   logic [DATA_W-1:0] sipo_exp;

   piso_serializer #(.DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .parallel_in (parallel_in),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .shift_en    (shift_en),
      .serial_out  (serial_out),
      .serial_valid(serial_valid),
      .frame_start (frame_start),
      .frame_last  (frame_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task checkValue(input string field, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s observed=%0h expected=%0h", cur_step, field, obs, exp);
      end
   endtask

   task checkOutput(input logic e_out, input logic e_valid, input logic e_start,
                    input logic e_last, input logic e_ready);
      checkValue("serial_out",   32'(serial_out),   32'(e_out));
      checkValue("serial_valid", 32'(serial_valid), 32'(e_valid));
      checkValue("frame_start",  32'(frame_start),  32'(e_start));
      checkValue("frame_last",   32'(frame_last),   32'(e_last));
      checkValue("load_ready",   32'(load_ready),   32'(e_ready));
   endtask

   // A frame is just the list of bits to emit: data MSB first, then the parity bit when enabled.
   task loadFrame(input logic [DATA_W-1:0] w);
      model_frame.delete();
      for (int i = DATA_W - 1; i >= 0; i--) model_frame.push_back(w[i]);
`ifdef PISO_PARITY_EN
      model_frame.push_back(^w);
`endif
      model_pos = 0;
   endtask

   task applyStimulus(input logic r, input logic lv, input logic [DATA_W-1:0] w, input logic se);
      logic busy, e_out, e_start, e_last, e_ready, accept, consumed, cons_bit;
      @(negedge clk);
      rst = r;
      load_valid = lv;
      parallel_in = w;
      shift_en = se;
      #1;
      busy    = (model_frame.size() != 0);
      e_out   = busy ? model_frame[model_pos] : 1'b0;
      e_start = busy && (model_pos == 0);
      e_last  = busy && (model_pos == model_frame.size() - 1);
      e_ready = !r && (!busy || (e_last && se));
      checkOutput(e_out, busy, e_start, e_last, e_ready);
      accept   = lv && e_ready;
      consumed = serial_valid && se && !r;
      cons_bit = serial_out;
      @(posedge clk);
      if (consumed) sipo = {sipo[DATA_W-2:0], cons_bit};
      if (r) begin
         model_frame.delete();
         model_pos = 0;
      end else begin
         if (busy && se) begin
            model_pos++;
            if (model_pos == model_frame.size()) begin
               model_frame.delete();
               model_pos = 0;
            end
         end
         if (accept) loadFrame(w);
      end
   endtask

   function automatic logic [DATA_W-1:0] sipoAfter(input logic [DATA_W-1:0] w);
`ifdef PISO_PARITY_EN
      return {w[DATA_W-2:0], ^w};
`else
      return w;
`endif
   endfunction

   initial begin
      rst = 1'b1;
      load_valid = 1'b0;
      parallel_in = '0;
      shift_en = 1'b0;

      cur_step = "reset";
      applyStimulus(1, 0, '0, 0);
      applyStimulus(1, 1, 4'hE, 1);
      cur_step = "after_reset";
      applyStimulus(0, 0, '0, 0);

      cur_step = "single_load";
      word = 4'hB;
      applyStimulus(0, 1, word, 1);
      repeat (FRAME_LEN) applyStimulus(0, 0, '0, 1);
      applyStimulus(0, 0, '0, 1);
      sipo_exp = sipoAfter(word);
      checkValue("sipo_word", 32'(sipo), 32'(sipo_exp));

      cur_step = "back_to_back";
      applyStimulus(0, 1, 4'hA, 1);
      repeat (FRAME_LEN) applyStimulus(0, 1, 4'h5, 1);
      repeat (FRAME_LEN) applyStimulus(0, 0, '0, 1);
      word = 4'h5;
      sipo_exp = sipoAfter(word);
      checkValue("sipo_word", 32'(sipo), 32'(sipo_exp));

      cur_step = "stall";
      applyStimulus(0, 1, 4'hC, 1);
      applyStimulus(0, 0, '0, 1);
      repeat (3) applyStimulus(0, 1, 4'h3, 0);
      repeat (FRAME_LEN - 1) applyStimulus(0, 0, '0, 1);
      applyStimulus(0, 0, '0, 1);

      cur_step = "reset_mid_frame";
      applyStimulus(0, 1, 4'hF, 1);
      repeat (2) applyStimulus(0, 0, '0, 1);
      applyStimulus(1, 0, '0, 1);
      applyStimulus(0, 1, 4'h3, 1);
      repeat (FRAME_LEN) applyStimulus(0, 0, '0, 1);
      applyStimulus(0, 0, '0, 0);

      cur_step = "load_when_busy";
      applyStimulus(0, 1, 4'h6, 1);
      applyStimulus(0, 0, '0, 1);
      applyStimulus(0, 1, 4'h9, 1);
      repeat (FRAME_LEN) applyStimulus(0, 0, '0, 1);

      cur_step = "random";
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                       DATA_W'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
